// File: rtl/adder_seq_nb.sv
// Multi-cycle add/sub: operands latched on start, summed CHUNK bits per clock LSB first via registered carry.
// Latency: done pulses WIDTH/CHUNK cycles after the accept edge; one op per WIDTH/CHUNK+1 cycles back-to-back.
// Backpressure: start honoured only while ready (IDLE/DONE); ADDER_FLAGS_EN adds overflow/zero outputs.
module adder_seq_nb #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef ADDER_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nxt;
  logic             carry_q, cout_q;
  logic             accept, last;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   chunk_res;
`ifdef ADDER_FLAGS_EN
  logic             ovf_q, zero_q;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        accept  = 1'b1;
      end
      RUN: if (last) state_d = DONE;
      DONE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last = (cnt_q == CW'(NCH - 1));

  // Constant-index chunk mux keeps every part-select static.
  always_comb begin
    a_ch    = '0;
    b_ch    = '0;
    sum_nxt = sum_q;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_q == CW'(i)) begin
        a_ch = a_q[i*CHUNK +: CHUNK];
        b_ch = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_res = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    for (int i = 0; i < NCH; i++) begin
      if (cnt_q == CW'(i)) sum_nxt[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? 1'b1 : carry_in;
        sum_q   <= '0;
        cnt_q   <= '0;
`ifdef ADDER_FLAGS_EN
        ovf_q   <= 1'b0;
        zero_q  <= 1'b0;
`endif
      end else if (state_q == RUN) begin
        sum_q   <= sum_nxt;
        carry_q <= chunk_res[CHUNK];
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          cout_q <= chunk_res[CHUNK];
`ifdef ADDER_FLAGS_EN
          ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nxt[WIDTH-1] != a_q[WIDTH-1]);
          zero_q <= (sum_nxt == '0);
`endif
        end
      end
    end
  end

  assign ready     = (state_q == IDLE) || (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef ADDER_FLAGS_EN
  assign overflow  = ovf_q;
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_adder_seq_nb.sv
// Scoreboard bench for adder_seq_nb (WIDTH=8, CHUNK=2): directed scenarios then randomized traffic.
module tb_adder_seq_nb;
  localparam int WIDTH = 8;
  localparam int CHUNK = 2;
  localparam int NCH   = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             reset, start, sub, carry_in;
  logic [WIDTH-1:0] a, b, sum;
  logic             ready, busy, done, carry_out;
`ifdef ADDER_FLAGS_EN
  logic             overflow, zero;
`endif

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    logic             z;
    int               t;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  adder_seq_nb #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .carry_in(carry_in), .ready(ready), .busy(busy), .done(done),
    .sum(sum), .carry_out(carry_out)
`ifdef ADDER_FLAGS_EN
    , .overflow(overflow), .zero(zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: whole-word arithmetic, no chunking.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic s, input logic ci);
    exp_t           e;
    logic [WIDTH:0] full;
    logic [WIDTH-1:0] bb;
    bb     = s ? ~bv : bv;
    full   = {1'b0, av} + {1'b0, bb} + {{WIDTH{1'b0}}, (s ? 1'b1 : ci)};
    e.s    = full[WIDTH-1:0];
    e.co   = full[WIDTH];
    e.ov   = (av[WIDTH-1] == bb[WIDTH-1]) && (e.s[WIDTH-1] != av[WIDTH-1]);
    e.z    = (e.s == '0);
    e.t    = 0;
    return e;
  endfunction

  // Called at a negedge with inputs already driven; accept happens on the next posedge.
  task automatic drive(input logic st, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic s, input logic ci);
    exp_t e;
    start = st; a = av; b = bv; sub = s; carry_in = ci;
    if (st && ready && !reset) begin
      e   = model(av, bv, s, ci);
      e.t = cyc + 1 + NCH;
      q.push_back(e);
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic s, input logic ci);
    @(negedge clk);
    drive(1'b1, av, bv, s, ci);
  endtask

  task automatic run_cycles(input string tag);
    for (int i = 0; i < NCH; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_ready"}, 32'(ready), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done=1 with no pending request (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("carry_out", 32'(carry_out), 32'(e.co));
        chk("done_latency", cyc, e.t);
`ifdef ADDER_FLAGS_EN
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("zero", 32'(zero), 32'(e.z));
`endif
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; carry_in = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(carry_out), 0);
    reset = 1'b0;

    // 1: all-zero operands, latency check via scoreboard
    issue(8'h00, 8'h00, 1'b0, 1'b0);
    run_cycles("t1");
    idle(2);
    // 2: add with carry_in and wrap
    issue(8'h96, 8'h6A, 1'b0, 1'b1);
    run_cycles("t2");
    idle(2);
    // 3: subtract with borrow, carry_in ignored
    issue(8'h05, 8'h07, 1'b1, 1'b1);
    run_cycles("t3");
    idle(2);
    // 4: signed overflow, then back-to-back accept in DONE
    issue(8'h7F, 8'h01, 1'b0, 1'b0);
    run_cycles("t4a");
    issue(8'h80, 8'h80, 1'b0, 1'b0);
    run_cycles("t4b");
    idle(2);
    // 5: start during RUN must be ignored
    issue(8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0);
    idle(5);
    // 6: reset two cycles into RUN aborts with no done
    issue(8'h33, 8'h44, 1'b0, 1'b0);
    idle(2);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_ready", 32'(ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(carry_out), 0);
    chk("abort_done", 32'(done), 0);
    reset = 1'b0;
    idle(NCH + 3);

    // Random traffic: starts land in IDLE, DONE (back-to-back) and RUN (ignored).
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      drive(($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    start = 1'b0;

    for (int k = 0; k < 4 * NCH && q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_done: %0d results outstanding, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_seq_nb.md
Name: adder_seq_nb

Overview:
Parametrised multi-cycle adder/subtractor. It is the next generation of the team's 4-bit ripple full adder. Operands of WIDTH bits are latched on a start handshake and summed CHUNK bits per clock, LSB chunk first, through a registered inter-chunk carry. Used on area-limited datapaths where a full-width carry chain does not meet timing. Reports completion with a one-cycle done pulse.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per clock; 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when ready=1.
sub  input  1  0: a+b+carry_in; 1: a-b (a + ~b + 1; carry_in ignored).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
carry_in  input  1  carry into bit 0 (add mode only).
ready  output  1  high in IDLE and DONE; start is accepted only when ready=1.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse: result valid.
sum  output  WIDTH  result.
carry_out  output  1  carry out of the MSB. In subtract mode, 1 = no borrow.
overflow  output  1  signed overflow (ADDER_FLAGS_EN only).
zero  output  1  sum == 0 (ADDER_FLAGS_EN only).

Behaviour:
- NCH = WIDTH/CHUNK. Chunk counter width is clog2(NCH), minimum 1.
- States: IDLE, RUN, DONE.
- Reset (synchronous, wins over everything): state=IDLE, cnt=0, sum=0, carry_out=0, done=0, busy=0, ready=1, overflow=0, zero=0.
- IDLE/DONE with start=1 on an edge (accept):
  - latch a and b, inverting b if sub=1;
  - carry register = sub ? 1 : carry_in;
  - sum cleared to 0; cnt=0; state goes to RUN.
- DONE with start=0: go to IDLE on the next edge. done is high only during the DONE cycle.
- RUN, each edge:
  - sum[cnt*CHUNK +: CHUNK] = a_chunk + b_chunk + carry (low CHUNK bits);
  - carry register = bit CHUNK of that addition;
  - cnt increments.
  - On the edge processing cnt=NCH-1: carry_out = final carry, state goes to DONE.
- Latency: start accepted at edge t, so done=1 after edge t+NCH. Back-to-back start in DONE gives throughput of one op per NCH+1 cycles.
- start while busy=1 is ignored. Operand inputs are don't-care outside the accept edge, because latched copies are used.
- sum and carry_out hold the last result until the next accept. During RUN, sum holds the partial result and is not valid.
- reset asserted mid-RUN aborts the operation; outputs return to reset values and no done is issued.
- Wrap-around: sum is modulo 2^WIDTH; the excess is reported only in carry_out.
- CHUNK=WIDTH is a legal degenerate case: single RUN cycle, done at t+1.

Optional Feature:
Macro ADDER_FLAGS_EN.
- Defined: overflow and zero ports exist and are registered on the final RUN edge. They hold with sum and are cleared on accept and on reset.
  - overflow = (msb of a == msb of effective b) && (msb of sum != msb of a).
  - zero = (final sum == 0).
- Undefined: both ports and their logic are absent. All other behaviour is identical.

Test Plan:
All scenarios use instance WIDTH=8, CHUNK=2.
1. Reset, then start with a=0x00, b=0x00, carry_in=0, sub=0 -> done pulses exactly 4 cycles after the accept edge; sum=0x00, carry_out=0, zero=1.
2. a=0x96, b=0x6A, carry_in=1, sub=0 -> sum=0x01, carry_out=1, overflow=0. busy=1 for 4 cycles and ready=0 throughout RUN.
3. a=0x05, b=0x07, sub=1, carry_in=1 -> sum=0xFE, carry_out=0 (borrow), overflow=0. Confirms carry_in is ignored in subtract mode.
4. a=0x7F, b=0x01, add mode -> sum=0x80, overflow=1. Then, in the DONE cycle, start with a=0x80, b=0x80, sub=0 -> accepted back-to-back; sum=0x00, carry_out=1, overflow=1, zero=1.
5. start pulsed again with a=0xFF during RUN of a 0x10+0x20 op -> ignored; result is 0x30 and only one done pulse occurs.
6. reset asserted 2 cycles into RUN -> next edge gives state IDLE, sum=0, carry_out=0, busy=0, ready=1; no done pulse follows.
